ext_trigger_seq: RTL
====================

Name: ext_trigger_seq

Overview:
- Clocked trigger sequencer directly upstream of the 32-ch / 8-pattern code table.
- Host loads a per-entry dwell time and a step count. On start, it preloads the table index and emits one trigger pulse per entry, walking the index downward.
- Trigger high time per entry comes from that entry's dwell. This replaces the host's hand-timed trigger and index-set strobes.

Parameters:
DEPTH, 8, number of dwell entries (matches table depth)
DWELL_W, 32, dwell counter width in iClk cycles
GAP_CYCLES, 2, trigger-low cycles between consecutive pulses (>=1)

Ports:
iClk  in  1  system clock
iRst  in  1  synchronous active-high reset
iSET_DWELL_FLAG  in  1  write strobe: dwell[iSET_STEP] <= iSET_DWELL
iSET_DWELL  in  DWELL_W  dwell value, cycles
iSET_STEP  in  8  dwell write address
iSET_COUNT_FLAG  in  1  write strobe: count <= iSET_COUNT
iSET_COUNT  in  8  number of steps per run
iStart  in  1  start run (level sampled per cycle)
iAbort  in  1  abort run
oSET_INDEX_FLAG  out  1  index-load strobe to table
oSET_INDEX  out  8  index value to table
oTrigger  out  1  trigger to table (code valid while high)
oStep  out  8  current table index mirror
oBusy  out  1  run in progress
oDone  out  1  one-cycle pulse, run completed normally

Behaviour:
- Reset: all outputs 0; dwell[] = 0; count = 0; state IDLE; counters 0.
- Dwell 0 is treated as 1 cycle. Writes with iSET_STEP >= DEPTH are ignored. count is clipped to DEPTH on write.
- Writes to dwell/count while oBusy=1 are ignored. Writes in IDLE take effect the next cycle.
- FSM states: IDLE, LOAD, SETTLE, HIGH, LOW, DONE. All transitions occur on the iClk rising edge.
- IDLE:
  - iStart=1, count!=0, iAbort=0 -> LOAD.
  - idx <= count-1.
  - Otherwise stay. Start with count=0 is ignored.
- LOAD (1 cycle):
  - oSET_INDEX_FLAG=1, oSET_INDEX=idx, oBusy=1.
  - -> SETTLE.
- SETTLE (1 cycle):
  - flag low; oSET_INDEX holds idx.
  - The falling flag edge commits the index in the table.
  - -> HIGH; load cnt = max(dwell[idx],1).
- HIGH:
  - oTrigger=1 for exactly max(dwell[idx],1) cycles.
  - Then -> LOW; load cnt = GAP_CYCLES.
- LOW:
  - oTrigger=0 for GAP_CYCLES cycles. The table decrements its index on the falling edge.
  - If idx==0 -> DONE.
  - Else idx <= idx-1 -> HIGH with new dwell.
- DONE (1 cycle): oDone=1, oBusy=0 -> IDLE.
- oBusy=1 in LOAD, SETTLE, HIGH, LOW. oStep=idx in all states.
- Latency: iStart sampled at edge T gives flag high in cycle T+1 and first trigger high from cycle T+3. Each step lasts dwell+GAP_CYCLES cycles.
- Total run: 2 + sum(max(dwell,1)) + count*GAP_CYCLES cycles, plus 1 DONE cycle.
- iAbort in any non-IDLE state:
  - Next edge: oTrigger=0, flag=0, oBusy=0, state IDLE; no oDone.
  - Abort wins over iStart in the same cycle.
- iStart while busy: ignored (no restart or queueing). iStart held high after DONE: a new run starts from IDLE.
- Reset mid-run: synchronous, same as power-up. Dwell and count are cleared.
- Counters are DWELL_W wide. No wrap is possible, since cnt only counts down to 1.

Test Plan:
- Reset, GAP_CYCLES=2, count=3, dwell[2]=4, dwell[1]=1, dwell[0]=3, iStart at T -> flag high at T+1 with oSET_INDEX=2. Trigger high T+3..T+6, T+9, T+12..T+14. oStep 2,1,0. oDone at T+17.
- count=0, iStart -> oBusy stays 0, no flag, no trigger.
- dwell[0]=0, count=1 -> one trigger of 1 cycle. oDone 3 cycles after trigger falls (2 gap + 1).
- iSET_COUNT=20 -> stored count 8; start gives oSET_INDEX=7 and 8 triggers. Write to iSET_STEP=9 leaves all dwells unchanged.
- iAbort asserted on 2nd cycle of a 5-cycle HIGH -> trigger low next cycle, oBusy 0, no oDone. A following iStart reruns from LOAD.
- Dwell write during HIGH (entry 0, value 9) ignored -> run uses old value. iRst mid-LOW -> all outputs 0 next cycle; a later start with count 0 does nothing.

Source files
------------

// File: rtl/ext_trigger_seq.sv
// Trigger sequencer feeding the code table: preloads the table index,
// then walks it downward emitting one dwell-timed trigger per entry.
module ext_trigger_seq #(
  parameter int DEPTH      = 8,
  parameter int DWELL_W    = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iSET_DWELL_FLAG,
  input  logic [DWELL_W-1:0] iSET_DWELL,
  input  logic [7:0]         iSET_STEP,
  input  logic               iSET_COUNT_FLAG,
  input  logic [7:0]         iSET_COUNT,
  input  logic               iStart,
  input  logic               iAbort,
  output logic               oSET_INDEX_FLAG,
  output logic [7:0]         oSET_INDEX,
  output logic               oTrigger,
  output logic [7:0]         oStep,
  output logic               oBusy,
  output logic               oDone
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH8 = 8'(DEPTH);
  localparam logic [DWELL_W-1:0] GAP = DWELL_W'(GAP_CYCLES);
  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, HIGH, LOW, DONE
  } state_t;

  state_t state, state_nxt;

  logic [DWELL_W-1:0] dwell [DEPTH];
  logic [7:0]         count;
  logic [7:0]         idx, idx_nxt, idx_m1;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [DWELL_W-1:0] dw_cur, dw_dec;

  // A zero dwell still produces a one-cycle trigger.
  function automatic logic [DWELL_W-1:0] eff(
    input logic [DWELL_W-1:0] d
  );
    return (d == '0) ? ONE : d;
  endfunction

  assign idx_m1 = idx - 8'd1;
  assign dw_cur = dwell[idx[AW-1:0]];
  assign dw_dec = dwell[idx_m1[AW-1:0]];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        dwell[i] <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      if (!oBusy && iSET_DWELL_FLAG &&
          iSET_STEP < DEPTH8)
        dwell[iSET_STEP[AW-1:0]] <= iSET_DWELL;
      if (!oBusy && iSET_COUNT_FLAG)
        count <= (iSET_COUNT > DEPTH8) ?
                 DEPTH8 : iSET_COUNT;
    end
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    cnt_nxt         = cnt;
    oSET_INDEX_FLAG = 1'b0;
    oSET_INDEX      = idx;
    oTrigger        = 1'b0;
    oStep           = idx;
    oBusy           = 1'b0;
    oDone           = 1'b0;
    unique case (state)
      IDLE: begin
        if (iStart && !iAbort && count != '0) begin
          state_nxt = LOAD;
          idx_nxt   = count - 8'd1;
        end
      end
      LOAD: begin
        oSET_INDEX_FLAG = 1'b1;
        oBusy           = 1'b1;
        state_nxt       = SETTLE;
      end
      SETTLE: begin
        oBusy     = 1'b1;
        state_nxt = HIGH;
        cnt_nxt   = eff(dw_cur);
      end
      HIGH: begin
        oTrigger = 1'b1;
        oBusy    = 1'b1;
        if (cnt <= ONE) begin
          state_nxt = LOW;
          cnt_nxt   = GAP;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      LOW: begin
        oBusy = 1'b1;
        if (cnt <= ONE) begin
          if (idx == '0) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx_m1;
            state_nxt = HIGH;
            cnt_nxt   = eff(dw_dec);
          end
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      DONE: begin
        oDone     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort freezes the index and drops straight back to idle.
    if (iAbort && state != IDLE) begin
      state_nxt = IDLE;
      idx_nxt   = idx;
      cnt_nxt   = '0;
    end
  end

endmodule
